// File: rtl/wb_write_queue_if.sv
// wb_write_queue_if: bundles the result handshake, the register-file write
// port and the forwarding lookup of wb_write_queue.
//   slave  : the queue itself
//   master : the datapath / register-file side that talks to the queue
interface wb_write_queue_if #(
  parameter int AW = 6,
  parameter int DW = 32
);
  // result handshake from the datapath
  logic          in_valid;
  logic          in_ready;
  logic [AW-1:0] in_reg;
  logic [DW-1:0] in_data;
  // drain control
  logic          wb_hold;
  // register-file write port
  logic          regWrite;
  logic [AW-1:0] writeReg;
  logic [DW-1:0] writeData;
  // pending-write lookup for decode-stage reads
  logic [AW-1:0] lk_reg;
  logic          lk_hit;
  logic [DW-1:0] lk_data;

  modport slave (
    input  in_valid, in_reg, in_data, wb_hold, lk_reg,
    output in_ready, regWrite, writeReg, writeData, lk_hit, lk_data
  );

  modport master (
    output in_valid, in_reg, in_data, wb_hold, lk_reg,
    input  in_ready, regWrite, writeReg, writeData, lk_hit, lk_data
  );
endinterface

// File: rtl/wb_write_queue.sv
// wb_write_queue: in-order writeback queue in front of the 64 x 32 register
// file. Results are accepted over a valid/ready handshake, kept in a circular
// buffer and drained one write per cycle onto regWrite/writeReg/writeData.
//
// Optional feature macro: WBQ_FWD_EN
//   defined   -> lk_hit/lk_data report the youngest queued write to lk_reg
//   undefined -> lookup logic absent, lk_hit/lk_data tied to zero
//
// Writes to register 0 are consumed by the handshake but never queued, since
// that register is hardwired to zero in the array.
module wb_write_queue #(
  parameter int DEPTH = 4,
  parameter int AW    = 6,
  parameter int DW    = 32
) (
  input logic             clk,
  input logic             rst,
  wb_write_queue_if.slave bus
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  localparam logic [CW-1:0] FULL_COUNT = CW'(DEPTH);
  localparam logic [CW-1:0] COUNT_ONE  = CW'(1);
  localparam logic [PW-1:0] PTR_ONE    = PW'(1);

  // queue storage and bookkeeping
  logic [AW-1:0] reg_mem_r  [DEPTH];
  logic [DW-1:0] data_mem_r [DEPTH];
  logic [PW-1:0] wr_ptr_r;
  logic [PW-1:0] rd_ptr_r;
  logic [CW-1:0] count_r;

  // handshake / drain decisions for the current cycle
  logic          in_ready_s;
  logic          push_s;
  logic          pop_s;

  // write-port and lookup values
  logic          reg_write_s;
  logic [AW-1:0] write_reg_s;
  logic [DW-1:0] write_data_s;
  logic          lk_hit_s;
  logic [DW-1:0] lk_data_s;

  // Handshake and drain decisions; ready looks only at reset and fill level,
  // so a full queue stalls one cycle even while the head is being written.
  always_comb begin
    in_ready_s = 1'b0;
    push_s     = 1'b0;
    pop_s      = 1'b0;
    if (rst) begin
      in_ready_s = 1'b0;
      push_s     = 1'b0;
      pop_s      = 1'b0;
    end else begin
      in_ready_s = (count_r != FULL_COUNT);
      push_s     = bus.in_valid && in_ready_s && (bus.in_reg != {AW{1'b0}});
      pop_s      = (count_r != {CW{1'b0}}) && !bus.wb_hold;
    end
  end

  // Pointer and occupancy update; simultaneous push and pop leave count alone.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_r <= {PW{1'b0}};
      rd_ptr_r <= {PW{1'b0}};
      count_r  <= {CW{1'b0}};
    end else begin
      if (push_s) begin
        wr_ptr_r <= wr_ptr_r + PTR_ONE;
      end else begin
        wr_ptr_r <= wr_ptr_r;
      end
      if (pop_s) begin
        rd_ptr_r <= rd_ptr_r + PTR_ONE;
      end else begin
        rd_ptr_r <= rd_ptr_r;
      end
      case ({push_s, pop_s})
        2'b10:   count_r <= count_r + COUNT_ONE;
        2'b01:   count_r <= count_r - COUNT_ONE;
        default: count_r <= count_r;
      endcase
    end
  end

  // Entry storage; contents are only meaningful below count, so no reset.
  always_ff @(posedge clk) begin
    if (push_s) begin
      reg_mem_r[wr_ptr_r]  <= bus.in_reg;
      data_mem_r[wr_ptr_r] <= bus.in_data;
    end else begin
      reg_mem_r[wr_ptr_r]  <= reg_mem_r[wr_ptr_r];
      data_mem_r[wr_ptr_r] <= data_mem_r[wr_ptr_r];
    end
  end

  // Present the head entry on the write port; fields are zero when idle so
  // the register file never sees stale data.
  always_comb begin
    reg_write_s  = 1'b0;
    write_reg_s  = {AW{1'b0}};
    write_data_s = {DW{1'b0}};
    if (pop_s) begin
      reg_write_s  = 1'b1;
      write_reg_s  = reg_mem_r[rd_ptr_r];
      write_data_s = data_mem_r[rd_ptr_r];
    end else begin
      reg_write_s  = 1'b0;
      write_reg_s  = {AW{1'b0}};
      write_data_s = {DW{1'b0}};
    end
  end

`ifdef WBQ_FWD_EN
  logic [PW-1:0] lk_idx_s;

  // Scan valid entries oldest to youngest so the last match (youngest) wins;
  // the head being written this cycle is still a valid entry.
  always_comb begin
    lk_hit_s  = 1'b0;
    lk_data_s = {DW{1'b0}};
    lk_idx_s  = rd_ptr_r;
    for (int i = 0; i < DEPTH; i++) begin
      lk_idx_s = rd_ptr_r + PW'(i);
      if (!rst && (CW'(i) < count_r) && (bus.lk_reg != {AW{1'b0}}) &&
          (reg_mem_r[lk_idx_s] == bus.lk_reg)) begin
        lk_hit_s  = 1'b1;
        lk_data_s = data_mem_r[lk_idx_s];
      end else begin
        lk_hit_s  = lk_hit_s;
        lk_data_s = lk_data_s;
      end
    end
  end
`else
  logic lk_unused_s;

  // Lookup disabled: answers are constant zero and the index is ignored.
  always_comb begin
    lk_hit_s    = 1'b0;
    lk_data_s   = {DW{1'b0}};
    lk_unused_s = ^bus.lk_reg;
  end
`endif

  assign bus.in_ready  = in_ready_s;
  assign bus.regWrite  = reg_write_s;
  assign bus.writeReg  = write_reg_s;
  assign bus.writeData = write_data_s;
  assign bus.lk_hit    = lk_hit_s;
  assign bus.lk_data   = lk_data_s;

endmodule

// File: tb/tb_wb_write_queue.sv
// tb_wb_write_queue: directed, table-driven bench for wb_write_queue
// (DEPTH 4). Each table row is one clock cycle: inputs are applied after the
// negedge and outputs compared 1 time unit later, before the next posedge.
module tb_wb_write_queue;

`ifdef WBQ_FWD_EN
  localparam bit FWD = 1'b1;
`else
  localparam bit FWD = 1'b0;
`endif

  logic clk;
  logic rst;

  wb_write_queue_if #(.AW(6), .DW(32)) bus ();

  wb_write_queue #(.DEPTH(4), .AW(6), .DW(32)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        rst;
    logic        vld;
    logic [5:0]  rg;
    logic [31:0] dat;
    logic        hold;
    logic [5:0]  lk;
    logic        e_rdy;
    logic        e_we;
    logic [5:0]  e_reg;
    logic [31:0] e_dat;
    logic        e_hit;
    logic [31:0] e_lk;
  } vec_t;

  vec_t vecs[$];
  int   n_cmp  = 0;
  int   n_fail = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  // one row: inputs, then expected ready / write port / lookup (lookup
  // expectations collapse to zero when forwarding is compiled out)
  task automatic addv(input logic r, input logic v, input logic [5:0] rg,
                      input logic [31:0] d, input logic h, input logic [5:0] lk,
                      input logic rdy, input logic we, input logic [5:0] wr,
                      input logic [31:0] wd, input logic hit, input logic [31:0] ld);
    vec_t t;
    t.rst = r; t.vld = v; t.rg = rg; t.dat = d; t.hold = h; t.lk = lk;
    t.e_rdy = rdy; t.e_we = we; t.e_reg = wr; t.e_dat = wd;
    t.e_hit = hit & FWD;
    t.e_lk  = FWD ? ld : 32'h0;
    vecs.push_back(t);
  endtask

  task automatic drive(input logic r, input logic v, input logic [5:0] rg,
                       input logic [31:0] d, input logic h, input logic [5:0] lk);
    rst = r; bus.in_valid = v; bus.in_reg = rg; bus.in_data = d;
    bus.wb_hold = h; bus.lk_reg = lk;
  endtask

  initial begin
    drive(1'b1, 1'b0, 6'd0, 32'h0, 1'b0, 6'd0);

    //    rst   vld   reg    data          hold  lk     rdy   we    wreg   wdata         hit   lkdata
    // reset: offered push refused, everything zero
    addv(1'b1, 1'b1, 6'd9,  32'h99,       1'b0, 6'd9,  1'b0, 1'b0, 6'd0,  32'h0,        1'b0, 32'h0);
    addv(1'b1, 1'b0, 6'd0,  32'h0,        1'b0, 6'd9,  1'b0, 1'b0, 6'd0,  32'h0,        1'b0, 32'h0);
    // single push, written the next cycle
    addv(1'b0, 1'b1, 6'd2,  32'h5,        1'b0, 6'd0,  1'b1, 1'b0, 6'd0,  32'h0,        1'b0, 32'h0);
    addv(1'b0, 1'b0, 6'd0,  32'h0,        1'b0, 6'd0,  1'b1, 1'b1, 6'd2,  32'h5,        1'b0, 32'h0);
    addv(1'b0, 1'b0, 6'd0,  32'h0,        1'b0, 6'd0,  1'b1, 1'b0, 6'd0,  32'h0,        1'b0, 32'h0);
    // fill under hold
    addv(1'b0, 1'b1, 6'd3,  32'h30,       1'b1, 6'd0,  1'b1, 1'b0, 6'd0,  32'h0,        1'b0, 32'h0);
    addv(1'b0, 1'b1, 6'd4,  32'h40,       1'b1, 6'd0,  1'b1, 1'b0, 6'd0,  32'h0,        1'b0, 32'h0);
    addv(1'b0, 1'b1, 6'd5,  32'h50,       1'b1, 6'd0,  1'b1, 1'b0, 6'd0,  32'h0,        1'b0, 32'h0);
    addv(1'b0, 1'b1, 6'd6,  32'h60,       1'b1, 6'd5,  1'b1, 1'b0, 6'd0,  32'h0,        1'b1, 32'h50);
    // full: push refused
    addv(1'b0, 1'b1, 6'd7,  32'h70,       1'b1, 6'd6,  1'b0, 1'b0, 6'd0,  32'h0,        1'b1, 32'h60);
    // release hold; full-with-pop still refuses the push
    addv(1'b0, 1'b1, 6'd8,  32'h80,       1'b0, 6'd3,  1'b0, 1'b1, 6'd3,  32'h30,       1'b1, 32'h30);
    addv(1'b0, 1'b0, 6'd0,  32'h0,        1'b0, 6'd3,  1'b1, 1'b1, 6'd4,  32'h40,       1'b0, 32'h0);
    addv(1'b0, 1'b0, 6'd0,  32'h0,        1'b0, 6'd5,  1'b1, 1'b1, 6'd5,  32'h50,       1'b1, 32'h50);
    addv(1'b0, 1'b0, 6'd0,  32'h0,        1'b0, 6'd8,  1'b1, 1'b1, 6'd6,  32'h60,       1'b0, 32'h0);
    addv(1'b0, 1'b0, 6'd0,  32'h0,        1'b0, 6'd0,  1'b1, 1'b0, 6'd0,  32'h0,        1'b0, 32'h0);
    // register 0 consumed, never written
    addv(1'b0, 1'b1, 6'd0,  32'hDEADBEEF, 1'b0, 6'd0,  1'b1, 1'b0, 6'd0,  32'h0,        1'b0, 32'h0);
    addv(1'b0, 1'b0, 6'd0,  32'h0,        1'b0, 6'd0,  1'b1, 1'b0, 6'd0,  32'h0,        1'b0, 32'h0);
    addv(1'b0, 1'b0, 6'd0,  32'h0,        1'b0, 6'd0,  1'b1, 1'b0, 6'd0,  32'h0,        1'b0, 32'h0);
    // hold mid-stream keeps the head
    addv(1'b0, 1'b1, 6'd10, 32'hA1,       1'b0, 6'd0,  1'b1, 1'b0, 6'd0,  32'h0,        1'b0, 32'h0);
    addv(1'b0, 1'b1, 6'd11, 32'hB2,       1'b0, 6'd0,  1'b1, 1'b1, 6'd10, 32'hA1,       1'b0, 32'h0);
    addv(1'b0, 1'b0, 6'd0,  32'h0,        1'b1, 6'd11, 1'b1, 1'b0, 6'd0,  32'h0,        1'b1, 32'hB2);
    addv(1'b0, 1'b0, 6'd0,  32'h0,        1'b0, 6'd0,  1'b1, 1'b1, 6'd11, 32'hB2,       1'b0, 32'h0);
    addv(1'b0, 1'b0, 6'd0,  32'h0,        1'b0, 6'd0,  1'b1, 1'b0, 6'd0,  32'h0,        1'b0, 32'h0);
    // same register twice: youngest wins, in-flight push not visible
    addv(1'b0, 1'b1, 6'd7,  32'h11,       1'b1, 6'd7,  1'b1, 1'b0, 6'd0,  32'h0,        1'b0, 32'h0);
    addv(1'b0, 1'b1, 6'd7,  32'h22,       1'b1, 6'd7,  1'b1, 1'b0, 6'd0,  32'h0,        1'b1, 32'h11);
    addv(1'b0, 1'b0, 6'd0,  32'h0,        1'b1, 6'd7,  1'b1, 1'b0, 6'd0,  32'h0,        1'b1, 32'h22);
    addv(1'b0, 1'b0, 6'd0,  32'h0,        1'b1, 6'd8,  1'b1, 1'b0, 6'd0,  32'h0,        1'b0, 32'h0);
    addv(1'b0, 1'b0, 6'd0,  32'h0,        1'b0, 6'd7,  1'b1, 1'b1, 6'd7,  32'h11,       1'b1, 32'h22);
    addv(1'b0, 1'b0, 6'd0,  32'h0,        1'b0, 6'd7,  1'b1, 1'b1, 6'd7,  32'h22,       1'b1, 32'h22);
    addv(1'b0, 1'b0, 6'd0,  32'h0,        1'b0, 6'd7,  1'b1, 1'b0, 6'd0,  32'h0,        1'b0, 32'h0);
    // three entries under hold, then reset discards them
    addv(1'b0, 1'b1, 6'd12, 32'hC1,       1'b1, 6'd0,  1'b1, 1'b0, 6'd0,  32'h0,        1'b0, 32'h0);
    addv(1'b0, 1'b1, 6'd13, 32'hC2,       1'b1, 6'd0,  1'b1, 1'b0, 6'd0,  32'h0,        1'b0, 32'h0);
    addv(1'b0, 1'b1, 6'd14, 32'hC3,       1'b1, 6'd12, 1'b1, 1'b0, 6'd0,  32'h0,        1'b1, 32'hC1);
    addv(1'b1, 1'b0, 6'd0,  32'h0,        1'b0, 6'd12, 1'b0, 1'b0, 6'd0,  32'h0,        1'b0, 32'h0);
    addv(1'b0, 1'b0, 6'd0,  32'h0,        1'b0, 6'd12, 1'b1, 1'b0, 6'd0,  32'h0,        1'b0, 32'h0);
    addv(1'b0, 1'b0, 6'd0,  32'h0,        1'b0, 6'd13, 1'b1, 1'b0, 6'd0,  32'h0,        1'b0, 32'h0);

    foreach (vecs[i]) begin
      @(negedge clk);
      drive(vecs[i].rst, vecs[i].vld, vecs[i].rg, vecs[i].dat, vecs[i].hold, vecs[i].lk);
      #1;
      chk($sformatf("v%0d.in_ready", i),  {31'h0, bus.in_ready}, {31'h0, vecs[i].e_rdy});
      chk($sformatf("v%0d.regWrite", i),  {31'h0, bus.regWrite}, {31'h0, vecs[i].e_we});
      chk($sformatf("v%0d.writeReg", i),  {26'h0, bus.writeReg}, {26'h0, vecs[i].e_reg});
      chk($sformatf("v%0d.writeData", i), bus.writeData,         vecs[i].e_dat);
      chk($sformatf("v%0d.lk_hit", i),    {31'h0, bus.lk_hit},   {31'h0, vecs[i].e_hit});
      chk($sformatf("v%0d.lk_data", i),   bus.lk_data,           vecs[i].e_lk);
    end

    // back-to-back pushes for 20 cycles: each value written one cycle later
    for (int i = 0; i <= 20; i++) begin
      @(negedge clk);
      if (i < 20) begin
        drive(1'b0, 1'b1, 6'((i % 63) + 1), 32'h1000 + 32'(i), 1'b0, 6'd0);
      end else begin
        drive(1'b0, 1'b0, 6'd0, 32'h0, 1'b0, 6'd0);
      end
      #1;
      chk($sformatf("b2b%0d.in_ready", i), {31'h0, bus.in_ready}, 32'h1);
      if (i == 0) begin
        chk("b2b0.regWrite", {31'h0, bus.regWrite}, 32'h0);
      end else begin
        chk($sformatf("b2b%0d.regWrite", i),  {31'h0, bus.regWrite}, 32'h1);
        chk($sformatf("b2b%0d.writeReg", i),  {26'h0, bus.writeReg}, 32'((i - 1) % 63 + 1));
        chk($sformatf("b2b%0d.writeData", i), bus.writeData,         32'h1000 + 32'(i - 1));
      end
    end
    @(negedge clk);
    #1;
    chk("b2b_drained.regWrite",  {31'h0, bus.regWrite}, 32'h0);
    chk("b2b_drained.writeData", bus.writeData,         32'h0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
